// File: rtl/ascii_int_parser_pkg.sv
// Shared constants for the ASCII integer parser: character codes, error codes, FSM states.
// The NEG state exists only when PARSER_NEG_EN is defined.
package ascii_int_parser_pkg;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_MINUS = 8'h2D;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_OVF     = 2'b10;
    localparam logic [1:0] ERR_SIGN    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NUM  = 2'd1,
        ST_SKIP = 2'd2
`ifdef PARSER_NEG_EN
        ,
        ST_NEG  = 2'd3
`endif
    } state_t;

    function automatic logic is_delim_char(input logic [7:0] ch);
        return (ch == CH_SP) || (ch == CH_CR) || (ch == CH_LF) || (ch == CH_TAB);
    endfunction

endpackage

// File: rtl/ascii_int_parser_if.sv
// Byte-stream input and parsed-number output bundle of the ASCII integer parser.
// master = byte source / number consumer, slave = parser.
interface ascii_int_parser_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
);
    logic              en;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              flush;
    logic [DATA_W-1:0] num;
    logic              num_valid;
    logic              err;
    logic [1:0]        err_code;
    logic              busy;
    logic [CNT_W-1:0]  num_cnt;

    modport master (
        output en, rx_data, rx_valid, flush,
        input  num, num_valid, err, err_code, busy, num_cnt
    );

    modport slave (
        input  en, rx_data, rx_valid, flush,
        output num, num_valid, err, err_code, busy, num_cnt
    );
endinterface

// File: rtl/ascii_int_parser_char_class.sv
// Combinational byte classifier: digit / whitespace delimiter / minus sign, plus digit value.
module ascii_int_parser_char_class
    import ascii_int_parser_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_digit,
    output logic       is_delim,
    output logic       is_minus,
    output logic [3:0] digit
);

    always_comb begin
        is_digit = (ch >= CH_0) && (ch <= CH_9);
        is_delim = is_delim_char(ch);
        is_minus = (ch == CH_MINUS);
        digit    = is_digit ? ch[3:0] : 4'd0;
    end

endmodule

// File: rtl/ascii_int_parser.sv
// Turns a whitespace-separated ASCII byte stream into unsigned (or, with PARSER_NEG_EN,
// signed) integers, flagging illegal characters, overflow and bare signs.
//
// state | meaning
// IDLE  | between tokens, delimiters ignored
// NUM   | accumulating digits of a token
// NEG   | '-' seen, waiting for first digit (PARSER_NEG_EN only)
// SKIP  | bad token, discard until delimiter/flush
module ascii_int_parser
    import ascii_int_parser_pkg::*;
#(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}},
    parameter int                CNT_W   = 8
) (
    input logic clk,
    input logic rst,
    ascii_int_parser_if.slave bus
);

    localparam int ACC_W = DATA_W + 4;

    state_t            state, state_nx;
    logic [ACC_W-1:0]  acc, acc_nx, acc_dig, limit;
    logic              neg, neg_nx, neg_eff, ovf;
    logic              emit, err_nx;
    logic [1:0]        code_nx;
    logic [DATA_W-1:0] num_emit;

    logic [DATA_W-1:0] num_q;
    logic              valid_q, err_q;
    logic [1:0]        code_q;
    logic [CNT_W-1:0]  cnt_q;

    logic       is_digit, is_delim, is_minus;
    logic [3:0] digit;

    ascii_int_parser_char_class u_class (
        .ch       (bus.rx_data),
        .is_digit (is_digit),
        .is_delim (is_delim),
        .is_minus (is_minus),
        .digit    (digit)
    );

`ifndef PARSER_NEG_EN
    logic unused_minus;
    assign unused_minus = is_minus;
`endif

    // Candidate accumulator after a digit; a fresh token starts from the digit itself.
    always_comb begin
        neg_eff = (state == ST_NUM) ? neg : (state != ST_IDLE);
        acc_dig = (state == ST_NUM) ? (acc << 3) + (acc << 1) + ACC_W'(digit)
                                    : ACC_W'(digit);
        limit   = ACC_W'(MAX_VAL) + ACC_W'(neg_eff);
        ovf     = acc_dig > limit;
    end

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        neg_nx   = neg;
        emit     = 1'b0;
        err_nx   = 1'b0;
        code_nx  = code_q;

        if (bus.rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (is_digit) begin
                        if (ovf) begin
                            state_nx = ST_SKIP;
                            err_nx   = 1'b1;
                            code_nx  = ERR_OVF;
                        end else begin
                            state_nx = ST_NUM;
                            acc_nx   = acc_dig;
                            neg_nx   = 1'b0;
                        end
                    end
`ifdef PARSER_NEG_EN
                    else if (is_minus) begin
                        state_nx = ST_NEG;
                        acc_nx   = '0;
                    end
`endif
                    else if (!is_delim) begin
                        state_nx = ST_SKIP;
                        err_nx   = 1'b1;
                        code_nx  = ERR_ILLEGAL;
                    end
                end
                ST_NUM: begin
                    if (is_digit) begin
                        if (ovf) begin
                            state_nx = ST_SKIP;
                            err_nx   = 1'b1;
                            code_nx  = ERR_OVF;
                        end else begin
                            acc_nx = acc_dig;
                        end
                    end else if (is_delim) begin
                        state_nx = ST_IDLE;
                        emit     = 1'b1;
                    end else begin
                        state_nx = ST_SKIP;
                        err_nx   = 1'b1;
                        code_nx  = ERR_ILLEGAL;
                    end
                end
`ifdef PARSER_NEG_EN
                ST_NEG: begin
                    if (is_digit) begin
                        if (ovf) begin
                            state_nx = ST_SKIP;
                            err_nx   = 1'b1;
                            code_nx  = ERR_OVF;
                        end else begin
                            state_nx = ST_NUM;
                            acc_nx   = acc_dig;
                            neg_nx   = 1'b1;
                        end
                    end else if (is_delim) begin
                        state_nx = ST_IDLE;
                        err_nx   = 1'b1;
                        code_nx  = ERR_SIGN;
                    end else begin
                        state_nx = ST_SKIP;
                        err_nx   = 1'b1;
                        code_nx  = ERR_ILLEGAL;
                    end
                end
`endif
                ST_SKIP: begin
                    if (is_delim) state_nx = ST_IDLE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end

        // Flush acts on the state reached after this cycle's byte, so digit+flush keeps the digit.
        if (bus.flush) begin
            case (state_nx)
                ST_NUM: begin
                    state_nx = ST_IDLE;
                    emit     = 1'b1;
                end
                ST_SKIP: state_nx = ST_IDLE;
`ifdef PARSER_NEG_EN
                ST_NEG: begin
                    state_nx = ST_IDLE;
                    err_nx   = 1'b1;
                    code_nx  = ERR_SIGN;
                end
`endif
                default: ;
            endcase
        end

        num_emit = neg_nx ? (~acc_nx[DATA_W-1:0] + 1'b1) : acc_nx[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            acc     <= '0;
            neg     <= 1'b0;
            num_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            cnt_q   <= '0;
        end else if (!bus.en) begin
            state   <= ST_IDLE;
            acc     <= '0;
            neg     <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nx;
            acc     <= acc_nx;
            neg     <= neg_nx;
            valid_q <= emit;
            err_q   <= err_nx;
            code_q  <= code_nx;
            if (emit) begin
                num_q <= num_emit;
                if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.num       = num_q;
    assign bus.num_valid = valid_q;
    assign bus.err       = err_q;
    assign bus.err_code  = code_q;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.num_cnt   = cnt_q;

endmodule

// File: tb/tb_ascii_int_parser.sv
// Directed bench for ascii_int_parser: default instance plus a MAX_VAL=100 instance on the same stream.
module tb_ascii_int_parser;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       flush;

    always #5 clk = ~clk;

    ascii_int_parser_if #(.DATA_W(32), .CNT_W(8)) bus ();
    ascii_int_parser_if #(.DATA_W(32), .CNT_W(8)) bus_s ();

    assign bus.en         = en;
    assign bus.rx_data    = rx_data;
    assign bus.rx_valid   = rx_valid;
    assign bus.flush      = flush;
    assign bus_s.en       = en;
    assign bus_s.rx_data  = rx_data;
    assign bus_s.rx_valid = rx_valid;
    assign bus_s.flush    = flush;

    ascii_int_parser #(.DATA_W(32), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ascii_int_parser #(.DATA_W(32), .MAX_VAL(32'd100), .CNT_W(8)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] numq[$];
    logic [31:0] numq_s[$];
    logic [1:0]  errq[$];
    logic [1:0]  errq_s[$];
    logic        bad_pulse = 1'b0;
    logic        prev_v    = 1'b0;
    logic        prev_e    = 1'b0;

    always @(negedge clk) begin
        if (bus.num_valid === 1'b1) numq.push_back(bus.num);
        if (bus.err === 1'b1) errq.push_back(bus.err_code);
        if (bus_s.num_valid === 1'b1) numq_s.push_back(bus_s.num);
        if (bus_s.err === 1'b1) errq_s.push_back(bus_s.err_code);
        if (bus.num_valid === 1'b1 && bus.err === 1'b1) bad_pulse = 1'b1;
        if (bus.num_valid === 1'b1 && prev_v) bad_pulse = 1'b1;
        if (bus.err === 1'b1 && prev_e) bad_pulse = 1'b1;
        prev_v = (bus.num_valid === 1'b1);
        prev_e = (bus.err === 1'b1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic v, input logic f);
        @(negedge clk);
        rx_data  = b;
        rx_valid = v;
        flush    = f;
        @(negedge clk);
        rx_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_q();
        numq.delete();
        errq.delete();
        numq_s.delete();
        errq_s.delete();
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        flush    = 1'b0;
        idle(3);
        rst = 1'b0;
        chk("rst_num", bus.num, 0);
        chk("rst_valid", bus.num_valid, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_code", bus.err_code, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cnt", bus.num_cnt, 0);
        clear_q();

        // "2 3 "
        send("2", 1'b1, 1'b0);
        chk("t1_busy_open", bus.busy, 1);
        send_str(" 3 ");
        idle(2);
        chk("t1_busy_closed", bus.busy, 0);
        chk("t1_nnum", numq.size(), 2);
        if (numq.size() == 2) begin
            chk("t1_num0", numq[0], 32'd2);
            chk("t1_num1", numq[1], 32'd3);
        end
        chk("t1_nerr", errq.size(), 0);
        chk("t1_cnt", bus.num_cnt, 2);
        clear_q();

        // "12\r\n 345  "
        send_str("12\r\n 345  ");
        idle(2);
        chk("t2_nnum", numq.size(), 2);
        if (numq.size() == 2) begin
            chk("t2_num0", numq[0], 32'd12);
            chk("t2_num1", numq[1], 32'd345);
        end
        chk("t2_nerr", errq.size(), 0);
        chk("t2_cnt", bus.num_cnt, 4);
        clear_q();

        // "4a5 6 "
        send("4", 1'b1, 1'b0);
        send("a", 1'b1, 1'b0);
        chk("t3_err_pulse", bus.err, 1);
        chk("t3_err_code", bus.err_code, 2'b01);
        chk("t3_busy_skip", bus.busy, 1);
        send_str("5 6 ");
        idle(2);
        chk("t3_nnum", numq.size(), 1);
        if (numq.size() == 1) chk("t3_num", numq[0], 32'd6);
        chk("t3_nerr", errq.size(), 1);
        chk("t3_code_held", bus.err_code, 2'b01);
        clear_q();

        // "101 100 " against MAX_VAL=100 on dut_s, no limit issue on dut
        send_str("10");
        chk("t4_no_err_yet", bus_s.err, 0);
        send("1", 1'b1, 1'b0);
        chk("t4_ovf_pulse", bus_s.err, 1);
        chk("t4_ovf_code", bus_s.err_code, 2'b10);
        send_str(" 100 ");
        idle(2);
        chk("t4s_nnum", numq_s.size(), 1);
        if (numq_s.size() == 1) chk("t4s_num", numq_s[0], 32'd100);
        chk("t4s_nerr", errq_s.size(), 1);
        chk("t4_nnum", numq.size(), 2);
        if (numq.size() == 2) begin
            chk("t4_num0", numq[0], 32'd101);
            chk("t4_num1", numq[1], 32'd100);
        end
        clear_q();

        // flush with no open token does nothing
        send(8'h00, 1'b0, 1'b1);
        idle(1);
        chk("idle_flush_nnum", numq.size(), 0);
        chk("idle_flush_nerr", errq.size(), 0);

        // "7" then "8"+flush in one cycle
        send("7", 1'b1, 1'b0);
        send("8", 1'b1, 1'b1);
        chk("t5_valid", bus.num_valid, 1);
        chk("t5_num", bus.num, 32'd78);
        chk("t5_busy", bus.busy, 0);
        chk("t5_cnt", bus.num_cnt, 8);
        idle(1);
        chk("t5_valid_1cyc", bus.num_valid, 0);
        clear_q();

        // enable drop mid-token
        send("9", 1'b1, 1'b0);
        chk("t5_busy_9", bus.busy, 1);
        en = 1'b0;
        idle(1);
        chk("t5_en_busy", bus.busy, 0);
        chk("t5_en_cnt", bus.num_cnt, 0);
        chk("t5_en_num_held", bus.num, 32'd78);
        en = 1'b1;
        send(8'h00, 1'b0, 1'b1);
        send(" ", 1'b1, 1'b0);
        idle(2);
        chk("t5_dropped", numq.size(), 0);
        clear_q();

        // "-5 - "
        send("-", 1'b1, 1'b0);
`ifdef PARSER_NEG_EN
        chk("t6_neg_busy", bus.busy, 1);
        chk("t6_neg_no_err", bus.err, 0);
`else
        chk("t6_minus_err", bus.err, 1);
        chk("t6_minus_code", bus.err_code, 2'b01);
`endif
        send_str("5 - ");
        idle(2);
`ifdef PARSER_NEG_EN
        chk("t6_nnum", numq.size(), 1);
        if (numq.size() == 1) chk("t6_num", numq[0], 32'hFFFF_FFFB);
        chk("t6_nerr", errq.size(), 1);
        if (errq.size() == 1) chk("t6_code", errq[0], 2'b11);
`else
        chk("t6_nnum", numq.size(), 0);
        chk("t6_nerr", errq.size(), 2);
        if (errq.size() == 2) chk("t6_code2", errq[1], 2'b01);
`endif
        clear_q();

        // magnitude boundary of the default instance
        send_str("2147483647 214748364");
        send("8", 1'b1, 1'b0);
        chk("bnd_ovf_pulse", bus.err, 1);
        chk("bnd_ovf_code", bus.err_code, 2'b10);
        send_str(" ");
        idle(2);
        chk("bnd_nnum", numq.size(), 1);
        if (numq.size() == 1) chk("bnd_num", numq[0], 32'h7FFF_FFFF);
        chk("bnd_nerr", errq.size(), 1);
        clear_q();

        // counter saturation
        en = 1'b0;
        idle(1);
        en = 1'b1;
        for (int i = 0; i < 300; i++) send("1", 1'b1, 1'b1);
        idle(2);
        chk("sat_cnt", bus.num_cnt, 8'hFF);
        chk("sat_nnum", numq.size(), 300);
        chk("sat_num", bus.num, 32'd1);

        chk("pulse_shape", bad_pulse, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
